// File: rtl/apb4_reg_native_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb2reg_pkg
// Description : Shared state encoding and constants for the APB4 to
//               register-native bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package apb2reg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_RESP = 3'd3,
        ST_ERR  = 3'd4
    } state_e;

    // Read data returned on an error response; sliced to DATA_WIDTH by users.
    localparam logic [1023:0] ERR_RDATA = '0;

    function automatic logic in_flight(input state_e s);
        return (s == ST_REQ) || (s == ST_WAIT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb4_reg_native_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : apb4_reg_native_bridge_if
// Description : APB4 completer signals plus the register-native request/ack
//               side of the bridge, bundled with master/slave modports.
// Revision    : 1.0 - initial release
// ============================================================================
interface apb4_reg_native_bridge_if #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [STRB_WIDTH-1:0] pstrb;
    logic                  pready;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pslverr;

    logic                  req_vld;
    logic                  wr_en;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_WIDTH-1:0] wr_be;
    logic                  ack_vld;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  to_err;

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb, ack_vld, rd_data,
        output pready, prdata, pslverr, req_vld, wr_en, rd_en, addr, wr_data,
               wr_be, to_err
    );

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb, ack_vld, rd_data,
        input  pready, prdata, pslverr, req_vld, wr_en, rd_en, addr, wr_data,
               wr_be, to_err
    );

endinterface
`default_nettype wire

// File: rtl/apb4_reg_native_bridge_timeout_cnt.sv
`default_nettype none
// ============================================================================
// Module      : apb2reg_timeout_cnt
// Description : Wait-state counter for the bridge; flags when the count
//               reaches TIMEOUT_CYCLES. Clear dominates increment.
// Revision    : 1.0 - initial release
// ============================================================================
module apb2reg_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  wire  clk,
    input  wire  rst_n,
    input  wire  clr_i,
    input  wire  inc_i,
    output logic expired_o
);
    localparam int unsigned     TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT_CYCLES);

    logic [TO_W-1:0] count_q;
    logic [TO_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == LIMIT);

endmodule
`default_nettype wire

// File: rtl/apb4_reg_native_bridge.sv
`default_nettype none
// ============================================================================
// Module      : apb4_reg_native_bridge
// Description : APB4 completer to register-native request/ack bridge with
//               range decode. Optional wait timeout: APB2REG_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module apb4_reg_native_bridge
    import apb2reg_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH     = 64,
    parameter int unsigned           DATA_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter logic [ADDR_WIDTH-1:0] ADDR_SPAN      = 'h1000,
    parameter int unsigned           TIMEOUT_CYCLES = 255
) (
    input wire                     clk,
    input wire                     rst_n,
    apb4_reg_native_bridge_if.slave bus
);
    localparam int unsigned       STRB_WIDTH = DATA_WIDTH / 8;
    // One extra bit so BASE_ADDR+ADDR_SPAN never wraps.
    localparam logic [ADDR_WIDTH:0] ADDR_LO = {1'b0, BASE_ADDR};
    localparam logic [ADDR_WIDTH:0] ADDR_HI = ADDR_LO + {1'b0, ADDR_SPAN};

    state_e                state_q;
    state_e                state_d;
    logic                  pwrite_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic [STRB_WIDTH-1:0] wr_be_q;
    logic [DATA_WIDTH-1:0] prdata_q;
    logic                  to_err_q;
    logic                  to_err_d;
    logic                  capture;
    logic                  load_rd;
    logic                  hit;
    logic                  expired;

    assign hit = ({1'b0, bus.paddr} >= ADDR_LO) && ({1'b0, bus.paddr} < ADDR_HI);

`ifdef APB2REG_TIMEOUT_EN
    logic cnt_active;
    assign cnt_active = in_flight(state_q);

    apb2reg_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (!cnt_active),
        .inc_i     (cnt_active && !bus.ack_vld),
        .expired_o (expired)
    );
`else
    assign expired = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        load_rd  = 1'b0;
        to_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.psel && !bus.penable) begin
                    capture = hit;
                    state_d = hit ? ST_REQ : ST_ERR;
                end
            end
            ST_REQ: begin
                if (bus.ack_vld) begin
                    load_rd = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.ack_vld) begin
                    load_rd = 1'b1;
                    state_d = ST_RESP;
                end else if (expired) begin
                    to_err_d = 1'b1;
                    state_d  = ST_ERR;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pwrite_q  <= 1'b0;
            addr_q    <= '0;
            wr_data_q <= '0;
            wr_be_q   <= '0;
            prdata_q  <= '0;
            to_err_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            to_err_q <= to_err_d;
            if (capture) begin
                pwrite_q  <= bus.pwrite;
                addr_q    <= bus.paddr - BASE_ADDR;
                wr_data_q <= bus.pwdata;
                wr_be_q   <= bus.pwrite ? bus.pstrb : '0;
            end else if ((state_q == ST_RESP) || (state_q == ST_ERR)) begin
                // Request fields read zero once the transfer has retired.
                pwrite_q  <= 1'b0;
                addr_q    <= '0;
                wr_data_q <= '0;
                wr_be_q   <= '0;
            end
            if (load_rd) begin
                prdata_q <= pwrite_q ? '0 : bus.rd_data;
            end else if (state_q == ST_RESP) begin
                prdata_q <= '0;
            end
        end
    end

    assign bus.req_vld = (state_q == ST_REQ);
    assign bus.wr_en   = (state_q == ST_REQ) && pwrite_q;
    assign bus.rd_en   = (state_q == ST_REQ) && !pwrite_q;
    assign bus.addr    = addr_q;
    assign bus.wr_data = wr_data_q;
    assign bus.wr_be   = wr_be_q;
    assign bus.to_err  = to_err_q;
    assign bus.pready  = (state_q == ST_RESP) || (state_q == ST_ERR);
    assign bus.pslverr = (state_q == ST_ERR);
    assign bus.prdata  = (state_q == ST_RESP) ? prdata_q : ERR_RDATA[DATA_WIDTH-1:0];

endmodule
`default_nettype wire
